// File: rtl/uart_receiver_os_if.sv
// Serial-side and host-side signal bundle for the oversampling UART receiver.
// The receiver takes the master modport; the host/line side takes the slave modport.
interface uart_receiver_os_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 sin;
    logic [1:0]           parity_mode;
    logic                 busy;
    logic                 rx_data_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 parity_error;
    logic                 frame_error;

    modport master (
        input  sample_tick, sin, parity_mode,
        output busy, rx_data_valid, rx_data, parity_error, frame_error
    );

    modport slave (
        output sample_tick, sin, parity_mode,
        input  busy, rx_data_valid, rx_data, parity_error, frame_error
    );
endinterface

// File: rtl/uart_receiver_os.sv
// Oversampling UART receiver: 2-flop input synchroniser, 3-sample majority vote per bit,
// runtime parity mode latched per frame, 1/2 stop bits, false-start rejection and break hold.
module uart_receiver_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input logic                clk,
    input logic                rst_n,
    uart_receiver_os_if.master bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] VOTE0    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] VOTE1    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] VOTE2    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

    state_e               state;
    logic                 sin_meta, sin_s, sin_prev;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 samp_a, samp_b;
    logic [1:0]           mode_q;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, ferr_acc;
    logic                 busy_q, valid_q, perr_q, ferr_q;
    logic [DATA_BITS-1:0] data_q;

    logic vote, par_en, ferr_now;

    // Majority of the two stored samples and the live third sample.
    always_comb begin
        vote     = (samp_a & samp_b) | (samp_a & sin_s) | (samp_b & sin_s);
        par_en   = mode_q[0] ^ mode_q[1];
        ferr_now = ferr_acc | ~vote;
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_meta <= 1'b1;
            sin_s    <= 1'b1;
        end else begin
            sin_meta <= bus.sin;
            sin_s    <= sin_meta;
        end
    end

    // Frame FSM with registered outputs; everything except the valid pulse moves on sample_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            sin_prev <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            mode_q   <= 2'b00;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.sample_tick) begin
                // Start needs a high-to-low edge, so a line left low never re-triggers.
                sin_prev <= sin_s;
                if (state != StIdle && state != StBreak) begin
                    tick_cnt <= (tick_cnt == TICK_END) ? '0 : tick_cnt + TW'(1);
                    if (tick_cnt == VOTE0) samp_a <= sin_s;
                    if (tick_cnt == VOTE1) samp_b <= sin_s;
                end
                unique case (state)
                    StIdle: begin
                        if (sin_prev && !sin_s) begin
                            state    <= StStart;
                            tick_cnt <= '0;
                            busy_q   <= 1'b1;
                            mode_q   <= bus.parity_mode;
                        end
                    end
                    StStart: begin
                        if (tick_cnt == VOTE2 && vote) begin
                            state  <= StIdle;
                            busy_q <= 1'b0;
                        end else if (tick_cnt == TICK_END) begin
                            state   <= StData;
                            bit_cnt <= '0;
                        end
                    end
                    StData: begin
                        if (tick_cnt == VOTE2) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (tick_cnt == TICK_END) begin
                            if (bit_cnt == DATA_END) begin
                                state    <= par_en ? StParity : StStop;
                                bit_cnt  <= '0;
                                ferr_acc <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                    StParity: begin
                        if (tick_cnt == VOTE2) par_bit <= vote;
                        if (tick_cnt == TICK_END) state <= StStop;
                    end
                    StStop: begin
                        if (tick_cnt == VOTE2) begin
                            ferr_acc <= ferr_now;
                            // Leave at the last stop vote so a back-to-back start is caught early.
                            if (bit_cnt == STOP_END) begin
                                valid_q <= 1'b1;
                                data_q  <= shreg;
                                perr_q  <= par_en & (^shreg ^ par_bit ^ mode_q[1]);
                                ferr_q  <= ferr_now;
                                if (ferr_now && shreg == '0) begin
                                    state <= StBreak;
                                end else begin
                                    state  <= StIdle;
                                    busy_q <= 1'b0;
                                end
                            end
                        end else if (tick_cnt == TICK_END) begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    StBreak: begin
                        if (sin_s) begin
                            state  <= StIdle;
                            busy_q <= 1'b0;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.rx_data_valid = valid_q;
    assign bus.rx_data       = data_q;
    assign bus.parity_error  = perr_q;
    assign bus.frame_error   = ferr_q;
endmodule

// File: tb/tb_uart_receiver_os.sv
// Self-checking bench for uart_receiver_os: stimulus pushes expected words into a queue,
// a monitor pops and compares on every rx_data_valid pulse.
module tb_uart_receiver_os;
    localparam int unsigned OS = 16;

    logic clk = 1'b0;
    logic rst_n;

    uart_receiver_os_if #(.DATA_BITS(8)) bus ();

    uart_receiver_os #(
        .DATA_BITS (8),
        .OVERSAMPLE(OS),
        .STOP_BITS (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   n_pulse    = 0;
    int   n_expected = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Parity error from the count of ones in data plus the received parity bit.
    function automatic logic model_perr(input logic [7:0] d, input logic [1:0] m, input logic p);
        int ones = int'(p);
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (m == 2'b01) return (ones % 2) != 0;
        if (m == 2'b10) return (ones % 2) != 1;
        return 1'b0;
    endfunction

    // Tick generator: one-clock pulse every 4 clocks, driven away from the active edge.
    initial begin
        int div = 0;
        bus.sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            bus.sample_tick = (div == 0);
        end
    end

    task automatic tick_wait(input int n);
        repeat (n) begin
            do @(posedge clk); while (!bus.sample_tick);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] m, input logic pbit,
                              input logic stopv, input bit spike, input logic [1:0] m_mid);
        exp_t e;
        bus.parity_mode = m;
        bus.sin = 1'b1;
        tick_wait(3);
        e.data = d;
        e.perr = model_perr(d, m, pbit);
        e.ferr = !stopv;
        exp_q.push_back(e);
        n_expected++;
        bus.sin = 1'b0;
        tick_wait(OS);
        bus.parity_mode = m_mid;
        for (int i = 0; i < 8; i++) begin
            bus.sin = d[i];
            if (spike) begin
                tick_wait(OS / 2 + 1);
                bus.sin = ~d[i];
                tick_wait(1);
                bus.sin = d[i];
                tick_wait(OS / 2 - 2);
            end else begin
                tick_wait(OS);
            end
        end
        if (m == 2'b01 || m == 2'b10) begin
            bus.sin = pbit;
            tick_wait(OS);
        end
        bus.sin = stopv;
        tick_wait(OS);
        bus.sin = 1'b1;
    endtask

    // Monitor: every valid pulse must match the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.rx_data_valid === 1'b1) begin
                n_pulse++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rx_data#%0d", n_pulse), 32'(bus.rx_data), 32'(e.data));
                    check($sformatf("parity_error#%0d", n_pulse), 32'(bus.parity_error),
                          32'(e.perr));
                    check($sformatf("frame_error#%0d", n_pulse), 32'(bus.frame_error),
                          32'(e.ferr));
                end
            end
        end
    end

    initial begin
        int         snap;
        logic [7:0] d;
        logic [1:0] m, mm;
        logic       p;

        rst_n = 1'b0;
        bus.sin = 1'b1;
        bus.parity_mode = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_valid", 32'(bus.rx_data_valid), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check("reset_perr", 32'(bus.parity_error), 32'd0);
        check("reset_ferr", 32'(bus.frame_error), 32'd0);
        rst_n = 1'b1;
        tick_wait(4);

        // Fixed words, no parity.
        send_frame(8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
        send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);

        // Random words, random parity mode/bit, mode scrambled mid-frame.
        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom_range(0, 255));
            m  = 2'($urandom_range(0, 3));
            mm = 2'($urandom_range(0, 3));
            p  = 1'($urandom_range(0, 1));
            send_frame(d, m, p, 1'b1, 1'b0, mm);
        end

        // Parity cases on 0x5A (four ones).
        send_frame(8'h5A, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01);
        send_frame(8'h5A, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01);
        send_frame(8'h5A, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10);
        send_frame(8'h5A, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10);

        // Bad stop bit, then a clean frame clears the error.
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        send_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);

        // Start glitch of 4 ticks.
        snap = n_pulse;
        bus.parity_mode = 2'b00;
        bus.sin = 1'b1;
        tick_wait(3);
        bus.sin = 1'b0;
        tick_wait(2);
        check("glitch_busy_set", 32'(bus.busy), 32'd1);
        tick_wait(2);
        bus.sin = 1'b1;
        tick_wait(OS / 2 - 1);
        check("glitch_busy_clear", 32'(bus.busy), 32'd0);
        tick_wait(OS);
        check("glitch_no_pulse", 32'(n_pulse), 32'(snap));

        // Break: line low for three frame times.
        bus.parity_mode = 2'b00;
        bus.sin = 1'b1;
        tick_wait(3);
        exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        n_expected++;
        snap = n_pulse;
        bus.sin = 1'b0;
        tick_wait(30 * OS);
        check("break_busy_held", 32'(bus.busy), 32'd1);
        check("break_one_pulse", 32'(n_pulse), 32'(snap + 1));
        bus.sin = 1'b1;
        tick_wait(4);
        check("break_busy_release", 32'(bus.busy), 32'd0);
        send_frame(8'h77, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);

        // Single-tick spikes at each data bit's centre vote.
        send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00);
        send_frame(8'($urandom_range(1, 255)), 2'b01, 1'b1, 1'b1, 1'b1, 2'b01);
        send_frame(8'h6E, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00);

        // Reset in the middle of the data bits.
        snap = n_pulse;
        bus.parity_mode = 2'b00;
        bus.sin = 1'b1;
        tick_wait(3);
        bus.sin = 1'b0;
        tick_wait(OS);
        bus.sin = 1'b1;
        tick_wait(OS);
        bus.sin = 1'b0;
        tick_wait(OS);
        bus.sin = 1'b1;
        tick_wait(5);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_valid", 32'(bus.rx_data_valid), 32'd0);
        check("midreset_rx_data", 32'(bus.rx_data), 32'd0);
        check("midreset_perr", 32'(bus.parity_error), 32'd0);
        check("midreset_ferr", 32'(bus.frame_error), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_wait(8 * OS);
        check("midreset_no_pulse", 32'(n_pulse), 32'(snap));
        send_frame(8'hE7, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00);

        // Drain: bounded wait for outstanding expectations.
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("pulse_count", 32'(n_pulse), 32'(n_expected));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
